// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues credit-limited imem requests,
// buffers in-order responses toward decode and squashes wrong-path fetches on redirect.

module fetch_ctrl_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          imem_rvalid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] fifo_count
);

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (outstanding == '0)))
        else $error("fetch_ctrl: imem_rvalid with no outstanding request");

    a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(fifo_count) <= 32'(DEPTH)))
        else $error("fetch_ctrl: response fifo count exceeds depth");

endmodule

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] squash_q, squash_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_pc_q [DEPTH];
    logic [31:0]   fifo_pc_d [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];

    logic [CW:0] inflight_s;
    logic        credit_ok_s;
    logic        accept_s;
    logic        rsp_s;
    logic        squash_hit_s;
    logic        push_s;
    logic        pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_PTR) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    // Handshake decode; a response with nothing outstanding is ignored.
    always_comb begin
        inflight_s   = {1'b0, outstanding_q} + {1'b0, count_q};
        credit_ok_s  = (inflight_s < DEPTH_W);
        imem_req     = rst_n && !redirect_valid && credit_ok_s;
        accept_s     = imem_req && imem_gnt;
        rsp_s        = imem_rvalid && (outstanding_q != '0);
        squash_hit_s = rsp_s && (squash_q != '0);
        push_s       = rsp_s && !squash_hit_s;
        if_valid     = (count_q != '0) && !redirect_valid;
        pop_s        = if_valid && if_ready;
        imem_addr    = pc_q;
        if_pc        = fifo_pc_q[rd_ptr_q];
        if_instr     = fifo_instr_q[rd_ptr_q];
    end

    // Next-state: a redirect overrides every other update in the same cycle.
    always_comb begin
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        squash_d     = squash_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;

        if (accept_s && !rsp_s) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (!accept_s && rsp_s) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end else begin
            outstanding_d = outstanding_q;
        end

        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the wrong path.
            pc_d      = redirect_addr;
            resp_pc_d = redirect_addr;
            squash_d  = outstanding_d;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (accept_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end

            if (squash_hit_s) begin
                squash_d = squash_q - CNT_ONE;
            end else begin
                squash_d = squash_q;
            end

            if (push_s) begin
                fifo_pc_d[wr_ptr_q]    = resp_pc_q;
                fifo_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d               = ptr_inc(wr_ptr_q);
                resp_pc_d              = resp_pc_q + 32'd4;
            end else begin
                wr_ptr_d  = wr_ptr_q;
                resp_pc_d = resp_pc_q;
            end

            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            if (push_s && !pop_s) begin
                count_d = count_q + CNT_ONE;
            end else if (!push_s && pop_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end
    end

    // State registers; reset returns to the post-reset fetch point with an empty buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            squash_q      <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= 32'h0000_0000;
                fifo_instr_q[i] <= 32'h0000_0000;
            end
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            squash_q      <= squash_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
        end
    end

    fetch_ctrl_chk #(
        .DEPTH(DEPTH),
        .CW   (CW)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_rvalid(imem_rvalid),
        .outstanding(outstanding_q),
        .fifo_count (count_q)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed + randomized bench for fetch_ctrl: an in-order memory model tags requests with
// a redirect epoch; surviving responses go to a scoreboard compared at each decode pop.

module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b1;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_ready      (if_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] xq[$];
    logic [31:0] pop_log[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    bit          mem_hold = 1'b0;
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] pl;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] first_pop();
        return (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF;
    endfunction

    // One clock: check at negedge, update the model, then present memory response.
    task automatic cycle();
        logic  exp_req;
        logic  exp_valid;
        logic  acc;
        mreq_t m;
        @(negedge clk);
        exp_req   = !redirect_valid && ((mq.size() + xq.size()) < DEPTH);
        exp_valid = (xq.size() != 0) && !redirect_valid;
        check("imem_addr", imem_addr, exp_addr);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("if_valid", 32'(if_valid), 32'(exp_valid));
        if (exp_valid && if_ready) begin
            check("if_pc", if_pc, xq[0]);
            check("if_instr", if_instr, instr_of(xq[0]));
            pop_log.push_back(xq[0]);
            void'(xq.pop_front());
        end
        acc = imem_req && imem_gnt;
        if (imem_rvalid && mq.size() > 0) begin
            m = mq.pop_front();
            if (m.epoch == epoch && !redirect_valid) xq.push_back(m.addr);
        end
        if (redirect_valid) begin
            epoch++;
            xq.delete();
            exp_addr = redirect_addr;
        end else if (acc) begin
            mq.push_back('{exp_addr, epoch, cyc + lat});
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        cyc++;
        #1;
        redirect_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc && !mem_hold) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        mq.delete();
        xq.delete();
        epoch++;
        exp_addr       = RESET_PC;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        pop_log.delete();
        cycle();
    endtask

    initial begin
        do_reset();

        // Streaming from reset with a 1-cycle memory.
        pop_log.delete();
        repeat (12) cycle();
        check("stream_first_pc", first_pop(), RESET_PC);
        check("stream_pops", 32'(pop_log.size() >= 3), 32'h1);

        // Decode stalls: buffer fills and issue stops, then drains in order.
        if_ready = 1'b0;
        repeat (6) cycle();
        check("stall_req", 32'(imem_req), 32'h0);
        check("stall_count", 32'(dut.count_q), 32'd2);
        check("stall_valid", 32'(if_valid), 32'h1);
        if_ready = 1'b1;
        repeat (6) cycle();

        // Redirect with one request in flight and one buffered entry.
        lat = 3;
        if_ready = 1'b0;
        redirect(32'h0000_0080);
        for (int i = 0; i < 40 && !(mq.size() == 1 && xq.size() == 1); i++) cycle();
        check("flush_setup", 32'(mq.size() == 1 && xq.size() == 1), 32'h1);
        redirect(32'h0000_0100);
        check("flush_addr", imem_addr, 32'h0000_0100);
        if_ready = 1'b1;
        repeat (14) cycle();
        check("flush_first_pc", first_pop(), 32'h0000_0100);

        // Redirect coinciding with a response, two requests in flight.
        mem_hold = 1'b1;
        for (int i = 0; i < 40 && mq.size() != 2; i++) cycle();
        check("coinc_setup", 32'(mq.size()), 32'd2);
        mem_hold = 1'b0;
        cycle();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0200;
        #1;
        check("coinc_req_low", 32'(imem_req), 32'h0);
        pop_log.delete();
        cycle();
        check("coinc_squash", 32'(dut.squash_q), 32'd1);
        check("coinc_addr", imem_addr, 32'h0000_0200);
        repeat (14) cycle();
        check("coinc_first_pc", first_pop(), 32'h0000_0200);

        // PC wrap at the top of the address space.
        lat = 1;
        redirect(32'hFFFF_FFF8);
        repeat (12) cycle();
        pl = (pop_log.size() > 2) ? pop_log[2] : 32'hFFFF_FFFF;
        check("wrap_first", first_pop(), 32'hFFFF_FFF8);
        check("wrap_zero", pl, 32'h0000_0000);

        // Back-to-back redirects: the later target wins.
        redirect(32'h0000_0300);
        redirect(32'h0000_0400);
        check("b2b_addr", imem_addr, 32'h0000_0400);
        repeat (10) cycle();
        check("b2b_first_pc", first_pop(), 32'h0000_0400);

        // Randomized grant, back-pressure, latency and redirects.
        for (int i = 0; i < 300; i++) begin
            imem_gnt = 1'($urandom_range(0, 3) != 0);
            if_ready = 1'($urandom_range(0, 2) != 0);
            mem_hold = 1'($urandom_range(0, 4) == 0);
            lat      = $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_addr  = $urandom() & 32'hFFFF_FFFC;
            end
            cycle();
        end
        imem_gnt = 1'b1;
        mem_hold = 1'b0;

        // Reset with a request in flight and a buffered entry.
        lat = 3;
        if_ready = 1'b0;
        redirect(32'h0000_0500);
        for (int i = 0; i < 40 && !(mq.size() == 1 && xq.size() == 1); i++) cycle();
        check("rst_mid_setup", 32'(mq.size() == 1 && xq.size() == 1), 32'h1);
        do_reset();
        #1;
        check("rst_rel_addr", imem_addr, RESET_PC);
        check("rst_rel_req", 32'(imem_req), 32'h1);
        if_ready = 1'b1;
        lat = 1;
        pop_log.delete();
        repeat (10) cycle();
        check("rst_rel_first_pc", first_pop(), RESET_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
